// File: rtl/hist_center_out_reader_pkg.sv
// Shared types and helpers for the centre-out histogram reader.
// Holds the FSM state encoding, default widths and saturation-limit helpers.
package hist_center_out_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SUM    = 2'd1,
    ST_PRE    = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam int DEF_BIN_AW = 11;
  localparam int DEF_RAM_DW = 19;
  localparam int DEF_OUT_DW = 12;
  localparam int DEF_SUM_DW = 19;
  localparam int DEF_DW     = 13;

  function automatic int nbins(input int aw);
    return 1 << aw;
  endfunction

  // Largest unsigned value representable in w bits (w < 31).
  function automatic int sat_lim(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/hist_center_out_reader_if.sv
// Bundles the start/mean request, histogram RAM read port, sum outputs and bin stream.
// master = the reader, slave = the surrounding logic (RAM, mapper, controller).
interface hist_center_out_reader_if
  import hist_center_out_reader_pkg::*;
#(
  parameter int BIN_AW = DEF_BIN_AW,
  parameter int RAM_DW = DEF_RAM_DW,
  parameter int OUT_DW = DEF_OUT_DW,
  parameter int SUM_DW = DEF_SUM_DW,
  parameter int DW     = DEF_DW
);

  logic              i_start;
  logic [DW-1:0]     i_data_aver;
  logic              o_ram_rd_en;
  logic [BIN_AW-1:0] o_ram_addr;
  logic [RAM_DW-1:0] i_ram_q;
  logic [SUM_DW-1:0] o_sum_min_aver;
  logic [SUM_DW-1:0] o_sum_max_aver;
  logic              o_sum_vld;
  logic              o_hist_rd_vld;
  logic [OUT_DW-1:0] o_hist_rd_data;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_data_aver, i_ram_q,
    output o_ram_rd_en, o_ram_addr, o_sum_min_aver, o_sum_max_aver, o_sum_vld,
           o_hist_rd_vld, o_hist_rd_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_data_aver, i_ram_q,
    input  o_ram_rd_en, o_ram_addr, o_sum_min_aver, o_sum_max_aver, o_sum_vld,
           o_hist_rd_vld, o_hist_rd_data, o_busy, o_done
  );

endinterface

// File: rtl/hist_order_addr_gen.sv
// Centre-out bin address walker: mean-1 down to 0, then mean up to the top bin.
// Loads on start, steps on adv; last flags the top bin of the ascending leg.
module hist_order_addr_gen #(
  parameter int BIN_AW = 11
) (
  input  logic              i_clk_2x,
  input  logic              i_rst,
  input  logic [BIN_AW-1:0] mean,
  input  logic              start,
  input  logic              adv,
  output logic [BIN_AW-1:0] addr,
  output logic              last
);

  logic up;

  always_ff @(posedge i_clk_2x or posedge i_rst) begin
    if (i_rst) begin
      addr <= '0;
      up   <= 1'b0;
    end else if (start) begin
      // mean = 0 has no descending leg, so begin directly on the ascending one
      if (mean == '0) begin
        addr <= '0;
        up   <= 1'b1;
      end else begin
        addr <= mean - 1'b1;
        up   <= 1'b0;
      end
    end else if (adv) begin
      if (up) begin
        addr <= addr + 1'b1;
      end else if (addr == '0) begin
        addr <= mean;
        up   <= 1'b1;
      end else begin
        addr <= addr - 1'b1;
      end
    end
  end

  assign last = up && (addr == '1);

endmodule

// File: rtl/hist_center_out_reader.sv
// Sums a histogram below/above the mean, then streams bins centre-out at one bin per two clocks.
// Stream starts NBINS+4 cycles after start and runs gap-free; the consumer cannot stall it.
module hist_center_out_reader
  import hist_center_out_reader_pkg::*;
#(
  parameter int BIN_AW = DEF_BIN_AW,
  parameter int RAM_DW = DEF_RAM_DW,
  parameter int OUT_DW = DEF_OUT_DW,
  parameter int SUM_DW = DEF_SUM_DW,
  parameter int DW     = DEF_DW
) (
  input  logic                    i_clk_2x,
  input  logic                    i_rst,
  hist_center_out_reader_if.master bus
);

  localparam int NBINS = nbins(BIN_AW);
  localparam int AW    = ((SUM_DW > RAM_DW) ? SUM_DW : RAM_DW) + 1;
  localparam logic [OUT_DW-1:0] OUT_MAX = OUT_DW'(sat_lim(OUT_DW));
  localparam logic [SUM_DW-1:0] SUM_MAX = SUM_DW'(sat_lim(SUM_DW));

  state_t            state, state_nxt;
  logic [BIN_AW-1:0] cnt, mean, bcnt;
  logic              pre_ph, ph, vld_r, all_iss, done_r;
  logic              acc_en, acc_lo_sel;
  logic [SUM_DW-1:0] acc_lo, acc_hi, acc_lo_nxt, acc_hi_nxt;
  logic [SUM_DW-1:0] sum_lo_r, sum_hi_r;
  logic              sum_vld_r;
  logic [OUT_DW-1:0] data_r, q_sat;
  logic              start_acc;
  logic              rd_en, issue, gen_start, gen_adv, gen_last;
  logic [BIN_AW-1:0] rd_addr, gen_addr;

  function automatic logic [SUM_DW-1:0] sat_add(input logic [SUM_DW-1:0] a,
                                                input logic [RAM_DW-1:0] b);
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    return (s > AW'(SUM_MAX)) ? SUM_MAX : s[SUM_DW-1:0];
  endfunction

  // done_r blocks a start in the done cycle so a new run begins the cycle after
  assign start_acc = (state == ST_IDLE) && bus.i_start && !done_r;
  assign q_sat     = (bus.i_ram_q > RAM_DW'(OUT_MAX)) ? OUT_MAX : bus.i_ram_q[OUT_DW-1:0];

  hist_order_addr_gen #(.BIN_AW(BIN_AW)) u_addr_gen (
    .i_clk_2x (i_clk_2x),
    .i_rst    (i_rst),
    .mean     (mean),
    .start    (gen_start),
    .adv      (gen_adv),
    .addr     (gen_addr),
    .last     (gen_last)
  );

  always_ff @(posedge i_clk_2x or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start_acc) state_nxt = ST_SUM;
      ST_SUM:    if (cnt == '1) state_nxt = ST_PRE;
      ST_PRE:    if (pre_ph) state_nxt = ST_STREAM;
      ST_STREAM: if (vld_r && ph && (bcnt == '1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The first stream read goes out in the second PRE cycle; later reads on phase0
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    gen_start = 1'b0;
    gen_adv   = 1'b0;
    issue     = 1'b0;
    unique case (state)
      ST_SUM: begin
        rd_en   = 1'b1;
        rd_addr = cnt;
      end
      ST_PRE: begin
        gen_start = !pre_ph;
        issue     = pre_ph;
      end
      ST_STREAM: issue = vld_r && !ph && !all_iss;
      default: ;
    endcase
    if (issue) begin
      rd_en   = 1'b1;
      rd_addr = gen_addr;
      gen_adv = !gen_last;
    end
  end

  always_comb begin
    acc_lo_nxt = acc_lo;
    acc_hi_nxt = acc_hi;
    if (acc_en) begin
      if (acc_lo_sel) acc_lo_nxt = sat_add(acc_lo, bus.i_ram_q);
      else            acc_hi_nxt = sat_add(acc_hi, bus.i_ram_q);
    end
  end

  always_ff @(posedge i_clk_2x or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= '0;
      mean       <= '0;
      bcnt       <= '0;
      pre_ph     <= 1'b0;
      ph         <= 1'b0;
      vld_r      <= 1'b0;
      all_iss    <= 1'b0;
      done_r     <= 1'b0;
      acc_en     <= 1'b0;
      acc_lo_sel <= 1'b0;
      acc_lo     <= '0;
      acc_hi     <= '0;
      sum_lo_r   <= '0;
      sum_hi_r   <= '0;
      sum_vld_r  <= 1'b0;
      data_r     <= '0;
    end else begin
      sum_vld_r  <= 1'b0;
      done_r     <= 1'b0;
      acc_en     <= (state == ST_SUM);
      acc_lo_sel <= (cnt < mean);
      acc_lo     <= acc_lo_nxt;
      acc_hi     <= acc_hi_nxt;
      if (issue && gen_last) all_iss <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start_acc) begin
            mean    <= ({1'b0, bus.i_data_aver} >= (DW+1)'(NBINS)) ? '1
                                                                 : bus.i_data_aver[BIN_AW-1:0];
            cnt     <= '0;
            acc_lo  <= '0;
            acc_hi  <= '0;
            all_iss <= 1'b0;
            pre_ph  <= 1'b0;
          end
        end
        ST_SUM: cnt <= cnt + 1'b1;
        ST_PRE: begin
          pre_ph <= ~pre_ph;
          if (!pre_ph) begin
            sum_lo_r  <= acc_lo_nxt;
            sum_hi_r  <= acc_hi_nxt;
            sum_vld_r <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (!vld_r) begin
            data_r <= q_sat;
            vld_r  <= 1'b1;
            ph     <= 1'b0;
            bcnt   <= '0;
          end else begin
            ph <= ~ph;
            if (ph) begin
              if (bcnt == '1) begin
                vld_r  <= 1'b0;
                data_r <= '0;
                done_r <= 1'b1;
              end else begin
                bcnt   <= bcnt + 1'b1;
                data_r <= q_sat;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ram_rd_en    = rd_en;
  assign bus.o_ram_addr     = rd_addr;
  assign bus.o_sum_min_aver = sum_lo_r;
  assign bus.o_sum_max_aver = sum_hi_r;
  assign bus.o_sum_vld      = sum_vld_r;
  assign bus.o_hist_rd_vld  = vld_r;
  assign bus.o_hist_rd_data = data_r;
  assign bus.o_busy         = (state != ST_IDLE);
  assign bus.o_done         = done_r;

endmodule

// File: tb/tb_hist_center_out_reader.sv
// Directed bench for hist_center_out_reader with an 8-bin histogram RAM model.
module tb_hist_center_out_reader;

  localparam int BIN_AW = 3;
  localparam int RAM_DW = 19;
  localparam int OUT_DW = 12;
  localparam int SUM_DW = 19;
  localparam int DW     = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hist_center_out_reader_if #(.BIN_AW(BIN_AW), .RAM_DW(RAM_DW), .OUT_DW(OUT_DW),
                              .SUM_DW(SUM_DW), .DW(DW)) bus ();

  hist_center_out_reader #(.BIN_AW(BIN_AW), .RAM_DW(RAM_DW), .OUT_DW(OUT_DW),
                           .SUM_DW(SUM_DW), .DW(DW)) dut (
    .i_clk_2x (clk),
    .i_rst    (rst),
    .bus      (bus)
  );

  logic [RAM_DW-1:0] mem [8];
  always @(posedge clk) if (bus.o_ram_rd_en) bus.i_ram_q <= mem[bus.o_ram_addr];

  int n_tot = 0;
  int n_bad = 0;
  int exp_s [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 carries i_start; every later cycle is checked at the falling edge.
  task automatic run(input int mean_in, input int exp_lo, input int exp_hi, input bit noisy);
    logic exp_en;
    @(negedge clk);
    bus.i_data_aver = DW'(mean_in);
    bus.i_start     = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      bus.i_start     = noisy && (k == 4 || k == 15);
      bus.i_data_aver = DW'(k);
      exp_en = (k <= 8) || (k == 10) || (k >= 12 && k <= 24 && (k % 2) == 0);
      chk("rd_en", 32'(bus.o_ram_rd_en), 32'(exp_en));
      if (k <= 8)       chk("rd_addr_sum", 32'(bus.o_ram_addr), 32'(k - 1));
      else if (!exp_en) chk("rd_addr_idle", 32'(bus.o_ram_addr), 32'd0);
      chk("sum_vld", 32'(bus.o_sum_vld), 32'(k == 10));
      if (k >= 10) begin
        chk("sum_min", 32'(bus.o_sum_min_aver), 32'(exp_lo));
        chk("sum_max", 32'(bus.o_sum_max_aver), 32'(exp_hi));
      end
      chk("hist_vld", 32'(bus.o_hist_rd_vld), 32'(k >= 12 && k <= 27));
      chk("hist_data", 32'(bus.o_hist_rd_data),
          (k >= 12 && k <= 27) ? 32'(exp_s[(k - 12) / 2]) : 32'd0);
      chk("done", 32'(bus.o_done), 32'(k == 28));
      chk("busy", 32'(bus.o_busy), 32'(k <= 27));
    end
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_data_aver = '0;
    for (int i = 0; i < 8; i++) mem[i] = RAM_DW'(i + 1);

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(bus.o_ram_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.o_ram_addr), 32'd0);
    chk("rst_sum_min", 32'(bus.o_sum_min_aver), 32'd0);
    chk("rst_sum_max", 32'(bus.o_sum_max_aver), 32'd0);
    chk("rst_sum_vld", 32'(bus.o_sum_vld), 32'd0);
    chk("rst_vld", 32'(bus.o_hist_rd_vld), 32'd0);
    chk("rst_data", 32'(bus.o_hist_rd_data), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    rst = 1'b0;

    exp_s = '{3, 2, 1, 4, 5, 6, 7, 8};
    run(3, 6, 30, 1'b0);

    exp_s = '{1, 2, 3, 4, 5, 6, 7, 8};
    run(0, 0, 36, 1'b0);

    exp_s = '{7, 6, 5, 4, 3, 2, 1, 8};
    run(9, 28, 8, 1'b0);

    mem[2] = 19'd5000;
    exp_s = '{4095, 2, 1, 4, 5, 6, 7, 8};
    run(3, 5003, 30, 1'b0);

    for (int i = 0; i < 8; i++) mem[i] = 19'd262144;
    exp_s = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    run(3, 524287, 524287, 1'b0);

    for (int i = 0; i < 8; i++) mem[i] = RAM_DW'(i + 1);
    exp_s = '{3, 2, 1, 4, 5, 6, 7, 8};
    run(3, 6, 30, 1'b1);

    // Abort mid-stream with an asynchronous reset, then a full fresh run
    @(negedge clk);
    bus.i_data_aver = DW'(3);
    bus.i_start     = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_abort_vld", 32'(bus.o_hist_rd_vld), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_vld", 32'(bus.o_hist_rd_vld), 32'd0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_data", 32'(bus.o_hist_rd_data), 32'd0);
    chk("abort_rd_en", 32'(bus.o_ram_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_busy", 32'(bus.o_busy), 32'd0);

    exp_s = '{5, 4, 3, 2, 1, 6, 7, 8};
    run(5, 15, 21, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
